mem_read_port: RTL
==================

Name: mem_read_port

Overview:
- Memory-stage responder for the read address and size produced by address generation.
- Accepts one read per instruction and fetches the containing 16-byte line(s) from the data cache over a req/ready + rvalid handshake.
- Extracts and zero-extends the 1/2/4/8-byte operand and holds the pipeline via STALL_OUT until the data is delivered.
- Splits line-crossing accesses into two cache reads.

Parameters:
ADDR_W, 32, byte address width
LINE_BYTES, 16, cache line size in bytes (power of two)

Ports:
CLK  in  1  clock
RST  in  1  synchronous reset, active-high
V  in  1  ME-stage latch valid
MEM_RD  in  1  instruction performs a memory read
RD_ADDR  in  ADDR_W  linear byte address from AG latch
DATA_SIZE  in  2  00=byte, 01=word, 10=dword, 11=qword (MMX)
STALL_IN  in  1  downstream stage cannot accept a result
INV_LINE  in  1  store-snoop invalidate (used only with line buffer)
INV_ADDR  in  ADDR_W  byte address of the snooped store
DC_REQ  out  1  cache read request
DC_ADDR  out  ADDR_W  line-aligned request address (low log2(LINE_BYTES) bits zero)
DC_READY  in  1  cache accepts the request this cycle
DC_RVALID  in  1  line data valid
DC_RDATA  in  8*LINE_BYTES  returned line, byte 0 in bits [7:0]
RD_DATA  out  64  zero-extended operand
RD_DATA_V  out  1  RD_DATA valid
STALL_OUT  out  1  holds AG/ME latches

Behaviour:
- Reset: state IDLE. DC_REQ=0, DC_ADDR=0, RD_DATA=0, RD_DATA_V=0. STALL_OUT=0 while RST=1. Captured address, size and line registers are cleared.
- Size decode: nbytes = 1, 2, 4 or 8. off = RD_ADDR[log2(LINE_BYTES)-1:0]. cross = (off + nbytes > LINE_BYTES).
- States: IDLE, REQ_LO, WAIT_LO, REQ_HI, WAIT_HI, DONE.
  - IDLE: on V&MEM_RD, capture addr/size/cross and go to REQ_LO. STALL_OUT=1 combinationally in the accept cycle.
  - REQ_LO: DC_REQ=1, DC_ADDR=line(addr). Address is held stable until DC_READY=1, then go to WAIT_LO.
  - WAIT_LO: on DC_RVALID, store line LO. If cross, go to REQ_HI; otherwise go to DONE.
  - REQ_HI / WAIT_HI: same handshake with DC_ADDR=line(addr)+LINE_BYTES. Line address wraps modulo 2^ADDR_W. On RVALID store line HI and go to DONE.
  - DONE: RD_DATA = ({HI,LO} >> 8*off) masked to nbytes, zero-extended to 64 (HI=0 when !cross). RD_DATA_V=1.
    - !STALL_IN: return to IDLE. A new V&MEM_RD in that cycle is not accepted; it is accepted in the next cycle from IDLE.
    - STALL_IN: hold DONE, with RD_DATA and RD_DATA_V stable.
- STALL_OUT=1 in all states except IDLE (no accept) and DONE with !STALL_IN.
- Latency, zero-wait cache (READY in the REQ cycle, RVALID the following cycle):
  - Accept at cycle 0, REQ at 1, RVALID at 2, RD_DATA_V at 3.
  - A crossing access adds 2 cycles.
- DC_RVALID arrives no earlier than the cycle after DC_READY. RVALID outside WAIT_LO/WAIT_HI is ignored.
- V=0 or MEM_RD=0 in IDLE: no request, STALL_OUT=0.
- RST asserted mid-transaction: immediate return to IDLE and DC_REQ dropped. A late RVALID is ignored.
- V is not re-sampled while busy; the captured request completes regardless of upstream changes.

Optional Feature:
MEM_READ_LINE_BUF_EN
- With the macro: a one-entry buffer holds the tag and data of the last LO line fetched.
  - A non-crossing read whose line tag matches goes IDLE->DONE, with no DC_REQ and RD_DATA_V one cycle after accept.
  - INV_LINE with a matching line(INV_ADDR) clears the entry in the same cycle. If invalidate and lookup coincide, the invalidate wins (treated as a miss).
  - RST clears the entry.
- Without the macro: INV_LINE/INV_ADDR are ignored and every read issues cache requests.

Decomposition:
- Shared package mem_pkg:
  - DATA_SIZE encodings and the size_to_bytes function
  - LINE_BYTES and OFF_W constants
  - the state enum
- One natural sub-module, mem_byte_align: combinational {HI,LO} shift, size mask and zero-extension, reused by the future write-merge path.

Test Plan:
- Dword read, RD_ADDR=0x0000_1004, LINE_BYTES=16, zero-wait cache, line bytes 0x00..0x0F:
  - DC_ADDR=0x0000_1000.
  - RD_DATA=0x0000_0000_0706_0504, RD_DATA_V at cycle 3.
  - STALL_OUT high in cycles 0-2.
- Crossing qword read, RD_ADDR=0x0000_200C:
  - Two requests, at 0x2000 then 0x2010.
  - RD_DATA = bytes 0x200C..0x2013 in little-endian order, valid at cycle 5.
- Cache backpressure: DC_READY low for 3 cycles.
  - DC_REQ/DC_ADDR held stable throughout.
  - RD_DATA_V delayed exactly 3 cycles.
- STALL_IN high for 2 cycles in DONE:
  - RD_DATA/RD_DATA_V held stable.
  - IDLE entered on the first !STALL_IN cycle.
- RST asserted while in WAIT_LO, with RVALID the next cycle:
  - All outputs 0, state IDLE.
  - RVALID ignored, no RD_DATA_V.
- With MEM_READ_LINE_BUF_EN:
  - A repeat byte read at 0x1007 after the 0x1004 read gives no DC_REQ and RD_DATA=0x07 one cycle after accept.
  - INV_LINE at 0x100A before the repeat read forces a DC_REQ.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory-stage read port: size encodings,
// default line geometry, the read FSM states and the size helpers.
package mem_pkg;

    localparam int LINE_BYTES = 16;
    localparam int OFF_W      = $clog2(LINE_BYTES);

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'b00,
        SZ_WORD  = 2'b01,
        SZ_DWORD = 2'b10,
        SZ_QWORD = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        IDLE,
        REQ_LO,
        WAIT_LO,
        REQ_HI,
        WAIT_HI,
        DONE
    } state_e;

    function automatic logic [3:0] size_to_bytes(input logic [1:0] size);
        logic [3:0] n;
        case (size_e'(size))
            SZ_BYTE:  n = 4'd1;
            SZ_WORD:  n = 4'd2;
            SZ_DWORD: n = 4'd4;
            default:  n = 4'd8;
        endcase
        return n;
    endfunction

    function automatic logic [63:0] size_mask(input logic [1:0] size);
        logic [63:0] m;
        case (size_e'(size))
            SZ_BYTE:  m = 64'h0000_0000_0000_00FF;
            SZ_WORD:  m = 64'h0000_0000_0000_FFFF;
            SZ_DWORD: m = 64'h0000_0000_FFFF_FFFF;
            default:  m = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_byte_align.sv
// Combinational operand extraction: shifts the {HI,LO} line pair down by the
// byte offset, then masks to the access size with zero-extension to 64 bits.
module mem_byte_align
    import mem_pkg::*;
#(
    parameter int LINE_SZ = LINE_BYTES
) (
    input  logic [8*LINE_SZ-1:0]         i_lo,
    input  logic [8*LINE_SZ-1:0]         i_hi,
    input  logic [$clog2(LINE_SZ)-1:0]   i_off,
    input  logic [1:0]                   i_size,
    output logic [63:0]                  o_data
);

    logic [16*LINE_SZ-1:0] w_pair;
    logic [63:0]           w_shifted;

    assign w_pair    = {i_hi, i_lo};
    // The operand never extends past the HI line, so the low 64 bits suffice.
    assign w_shifted = 64'(w_pair >> {i_off, 3'b000});
    assign o_data    = w_shifted & size_mask(i_size);

endmodule

// File: rtl/mem_read_port.sv
// Memory-stage read responder: fetches one or two cache lines per read and
// returns the zero-extended operand. Optional line buffer: MEM_READ_LINE_BUF_EN.
module mem_read_port #(
    parameter int ADDR_W     = 32,
    parameter int LINE_BYTES = mem_pkg::LINE_BYTES
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    V,
    input  logic                    MEM_RD,
    input  logic [ADDR_W-1:0]       RD_ADDR,
    input  logic [1:0]              DATA_SIZE,
    input  logic                    STALL_IN,
    input  logic                    INV_LINE,
    input  logic [ADDR_W-1:0]       INV_ADDR,
    output logic                    DC_REQ,
    output logic [ADDR_W-1:0]       DC_ADDR,
    input  logic                    DC_READY,
    input  logic                    DC_RVALID,
    input  logic [8*LINE_BYTES-1:0] DC_RDATA,
    output logic [63:0]             RD_DATA,
    output logic                    RD_DATA_V,
    output logic                    STALL_OUT
);

    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int TAG_W  = ADDR_W - OFF_W;
    localparam int LINE_W = 8 * LINE_BYTES;
    localparam logic [OFF_W:0] LINE_END = (OFF_W + 1)'(LINE_BYTES);

    mem_pkg::state_e   r_state, w_state_nxt;
    logic [TAG_W-1:0]  r_tag;
    logic [OFF_W-1:0]  r_off;
    logic [1:0]        r_size;
    logic              r_cross;
    logic [LINE_W-1:0] r_lo, r_hi;

    logic [TAG_W-1:0]  w_in_tag, w_hi_tag;
    logic [OFF_W-1:0]  w_in_off;
    logic [OFF_W:0]    w_end;
    logic              w_in_cross, w_accept, w_buf_hit;
    logic [LINE_W-1:0] w_buf_data;
    logic [63:0]       w_aligned;

    assign w_in_tag   = RD_ADDR[ADDR_W-1:OFF_W];
    assign w_in_off   = RD_ADDR[OFF_W-1:0];
    assign w_end      = {1'b0, w_in_off} + (OFF_W + 1)'(mem_pkg::size_to_bytes(DATA_SIZE));
    assign w_in_cross = (w_end > LINE_END);
    assign w_accept   = (r_state == mem_pkg::IDLE) && V && MEM_RD;
    assign w_hi_tag   = r_tag + TAG_W'(1);

`ifdef MEM_READ_LINE_BUF_EN
    logic              r_buf_v;
    logic [TAG_W-1:0]  r_buf_tag;
    logic [LINE_W-1:0] r_buf_data;
    logic              w_inv_hit, w_fill, w_fill_inv;
    logic              w_unused_inv_off;

    assign w_unused_inv_off = ^INV_ADDR[OFF_W-1:0];
    assign w_inv_hit  = INV_LINE && r_buf_v && (INV_ADDR[ADDR_W-1:OFF_W] == r_buf_tag);
    // An invalidate in the lookup cycle wins, so the lookup sees a miss.
    assign w_buf_hit  = r_buf_v && !w_inv_hit && (w_in_tag == r_buf_tag) && !w_in_cross;
    assign w_buf_data = r_buf_data;
    assign w_fill     = (r_state == mem_pkg::WAIT_LO) && DC_RVALID;
    assign w_fill_inv = INV_LINE && (INV_ADDR[ADDR_W-1:OFF_W] == r_tag);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_buf_v    <= 1'b0;
            r_buf_tag  <= '0;
            r_buf_data <= '0;
        end else begin
            if (w_inv_hit)
                r_buf_v <= 1'b0;
            if (w_fill) begin
                r_buf_v    <= !w_fill_inv;
                r_buf_tag  <= r_tag;
                r_buf_data <= DC_RDATA;
            end
        end
    end
`else
    logic w_unused_inv;

    assign w_unused_inv = ^{INV_LINE, INV_ADDR};
    assign w_buf_hit    = 1'b0;
    assign w_buf_data   = '0;
`endif

    // NOTE: sequential state uses non-blocking assignments only; the line
    // registers are small flops, not a memory, so they are cleared on reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= mem_pkg::IDLE;
            r_tag   <= '0;
            r_off   <= '0;
            r_size  <= '0;
            r_cross <= 1'b0;
            r_lo    <= '0;
            r_hi    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_tag   <= w_in_tag;
                r_off   <= w_in_off;
                r_size  <= DATA_SIZE;
                r_cross <= w_in_cross;
                r_lo    <= w_buf_data;
                r_hi    <= '0;
            end
            if ((r_state == mem_pkg::WAIT_LO) && DC_RVALID)
                r_lo <= DC_RDATA;
            if ((r_state == mem_pkg::WAIT_HI) && DC_RVALID)
                r_hi <= DC_RDATA;
        end
    end

    // NOTE: every output and the next state get a default first, so no latches.
    always_comb begin
        w_state_nxt = r_state;
        DC_REQ      = 1'b0;
        DC_ADDR     = '0;
        RD_DATA_V   = 1'b0;
        STALL_OUT   = 1'b0;
        case (r_state)
            mem_pkg::IDLE: begin
                STALL_OUT = V && MEM_RD;
                if (V && MEM_RD)
                    w_state_nxt = w_buf_hit ? mem_pkg::DONE : mem_pkg::REQ_LO;
            end
            mem_pkg::REQ_LO: begin
                DC_REQ    = 1'b1;
                DC_ADDR   = {r_tag, {OFF_W{1'b0}}};
                STALL_OUT = 1'b1;
                if (DC_READY)
                    w_state_nxt = mem_pkg::WAIT_LO;
            end
            mem_pkg::WAIT_LO: begin
                STALL_OUT = 1'b1;
                if (DC_RVALID)
                    w_state_nxt = r_cross ? mem_pkg::REQ_HI : mem_pkg::DONE;
            end
            mem_pkg::REQ_HI: begin
                DC_REQ    = 1'b1;
                DC_ADDR   = {w_hi_tag, {OFF_W{1'b0}}};
                STALL_OUT = 1'b1;
                if (DC_READY)
                    w_state_nxt = mem_pkg::WAIT_HI;
            end
            mem_pkg::WAIT_HI: begin
                STALL_OUT = 1'b1;
                if (DC_RVALID)
                    w_state_nxt = mem_pkg::DONE;
            end
            mem_pkg::DONE: begin
                RD_DATA_V = 1'b1;
                STALL_OUT = STALL_IN;
                if (!STALL_IN)
                    w_state_nxt = mem_pkg::IDLE;
            end
            default: w_state_nxt = mem_pkg::IDLE;
        endcase
        // Reset silences the port in the same cycle it is asserted.
        if (RST) begin
            DC_REQ    = 1'b0;
            DC_ADDR   = '0;
            RD_DATA_V = 1'b0;
            STALL_OUT = 1'b0;
        end
    end

    mem_byte_align #(
        .LINE_SZ (LINE_BYTES)
    ) u_align (
        .i_lo   (r_lo),
        .i_hi   (r_hi),
        .i_off  (r_off),
        .i_size (r_size),
        .o_data (w_aligned)
    );

    assign RD_DATA = RD_DATA_V ? w_aligned : 64'd0;

endmodule
